// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD_WAIT = 2'd1,
    ARB_WR_WAIT = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Latched memory request: address and write data held for the access.
  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between the I-port and D-port.
// With MEM_ARB_RR_EN defined, ties go to the port that did not win last;
// otherwise the D-port always wins a tie.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
`ifdef MEM_ARB_RR_EN
  input  logic i_last_grant,
`endif
  output logic o_valid_c,
  output logic o_port_c
);

  // Select the winning port from the current requests.
  always_comb begin
    o_valid_c = i_ireq | i_dreq;
    o_port_c  = PORT_I;
    if (i_dreq) begin
      o_port_c = PORT_D;
`ifdef MEM_ARB_RR_EN
      if (i_ireq) begin
        o_port_c = ~i_last_grant;
      end
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and data
// access (read/write), sequencing readM/writeM against the memory's
// input_ready/ack_output completion pulses.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 input_ready,
  input  logic                 ack_output,
  output logic                 owner
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic                 r_readM;
  logic                 w_readM_nxt;
  logic                 r_writeM;
  logic                 w_writeM_nxt;
  arb_req_t             r_req;
  arb_req_t             w_req_nxt;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] w_rdata_nxt;
  logic                 r_i_ack;
  logic                 w_i_ack_nxt;
  logic                 r_d_ack;
  logic                 w_d_ack_nxt;
  logic                 r_owner;
  logic                 w_owner_nxt;
  logic                 w_pick_valid;
  logic                 w_pick_port;
  logic                 w_sel_we;

`ifdef MEM_ARB_RR_EN
  logic                 r_last_grant;
  logic                 w_last_grant_nxt;
`endif

  arb_pick u_pick (
    .i_ireq       (i_req),
    .i_dreq       (d_req),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_valid_c    (w_pick_valid),
    .o_port_c     (w_pick_port)
  );

  // Only the D-port may write; d_we is meaningless for an I-port grant.
  assign w_sel_we = (w_pick_port == PORT_D) && d_we;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_readM_nxt  = r_readM;
    w_writeM_nxt = r_writeM;
    w_req_nxt    = r_req;
    w_rdata_nxt  = r_rdata;
    w_i_ack_nxt  = 1'b0;
    w_d_ack_nxt  = 1'b0;
    w_owner_nxt  = r_owner;
`ifdef MEM_ARB_RR_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt    = w_pick_port;
`ifdef MEM_ARB_RR_EN
          w_last_grant_nxt = w_pick_port;
`endif
          w_req_nxt.addr = (w_pick_port == PORT_D) ? d_addr : i_addr;
          if (w_sel_we) begin
            w_req_nxt.wdata = d_wdata;
            w_writeM_nxt    = 1'b1;
            w_state_nxt     = ARB_WR_WAIT;
          end else begin
            w_readM_nxt = 1'b1;
            w_state_nxt = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        if (input_ready) begin
          w_rdata_nxt = data;
          w_readM_nxt = 1'b0;
          if (r_owner == PORT_D) begin
            w_d_ack_nxt = 1'b1;
          end else begin
            w_i_ack_nxt = 1'b1;
          end
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_WR_WAIT: begin
        if (ack_output) begin
          w_writeM_nxt = 1'b0;
          w_d_ack_nxt  = 1'b1;
          w_state_nxt  = ARB_IDLE;
        end
      end
      default: begin
        w_readM_nxt  = 1'b0;
        w_writeM_nxt = 1'b0;
        w_state_nxt  = ARB_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ARB_IDLE;
      r_readM  <= 1'b0;
      r_writeM <= 1'b0;
      r_req    <= '0;
      r_rdata  <= '0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_owner  <= PORT_I;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= PORT_I;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_readM  <= w_readM_nxt;
      r_writeM <= w_writeM_nxt;
      r_req    <= w_req_nxt;
      r_rdata  <= w_rdata_nxt;
      r_i_ack  <= w_i_ack_nxt;
      r_d_ack  <= w_d_ack_nxt;
      r_owner  <= w_owner_nxt;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= w_last_grant_nxt;
`endif
    end
  end

  assign readM   = r_readM;
  assign writeM  = r_writeM;
  assign address = r_req.addr;
  assign rdata   = r_rdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign owner   = r_owner;

  // Drive the shared bus only during a write.
  assign data = r_writeM ? r_req.wdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized
// accesses against a transaction-level model of the arbiter and memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        input_ready;
  logic        ack_output;
  logic        owner;

  logic [15:0] mem [0:255];
  logic [15:0] mem_rd;
  logic [15:0] exp_rdata;
  int          errors = 0;
  int          checks = 0;
`ifdef MEM_ARB_RR_EN
  logic        m_last;
`endif

  mem_port_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .rdata       (rdata),
    .readM       (readM),
    .writeM      (writeM),
    .address     (address),
    .data        (data),
    .input_ready (input_ready),
    .ack_output  (ack_output),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  // Memory model: returns the word at the presented address while readM is high.
  assign mem_rd = mem[address[7:0]];
  assign data   = readM ? mem_rd : 16'hzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access: request, strobe, optional spurious pulses, completion, ack.
  task automatic access(input logic ir, input logic dr, input logic dwe,
                        input logic [15:0] ia, input logic [15:0] da,
                        input logic [15:0] wd, input int lat,
                        input logic hold, input logic spur);
    logic        win;
    logic        wr;
    logic [15:0] ea;
    i_req = ir; d_req = dr; d_we = dwe;
    i_addr = ia; d_addr = da; d_wdata = wd;
    win = dr;
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      win = ~m_last;
`else
      win = 1'b1;
`endif
    end
`ifdef MEM_ARB_RR_EN
    m_last = win;
`endif
    wr = win && dwe;
    ea = win ? da : ia;
    tick();
    chk("grant_owner", 16'(owner), 16'(win));
    chk("grant_readM", 16'(readM), 16'(!wr));
    chk("grant_writeM", 16'(writeM), 16'(wr));
    chk("grant_address", address, ea);
    chk("grant_no_ack", 16'({i_ack, d_ack}), 16'd0);
    if (wr) chk("write_data_bus", data, wd);
    for (int j = 1; j < lat; j++) begin
      if (spur) begin
        if (wr) input_ready = 1'b1; else ack_output = 1'b1;
      end
      tick();
      input_ready = 1'b0; ack_output = 1'b0;
      chk("wait_strobes", 16'({readM, writeM}), wr ? 16'd1 : 16'd2);
      chk("wait_no_ack", 16'({i_ack, d_ack}), 16'd0);
      chk("wait_address", address, ea);
    end
    if (wr) ack_output = 1'b1; else input_ready = 1'b1;
    if (spur) begin input_ready = 1'b1; ack_output = 1'b1; end
    if (!wr) exp_rdata = mem[ea[7:0]];
    tick();
    input_ready = 1'b0; ack_output = 1'b0;
    chk("done_i_ack", 16'(i_ack), 16'(!win));
    chk("done_d_ack", 16'(d_ack), 16'(win));
    chk("done_strobes", 16'({readM, writeM}), 16'd0);
    chk("done_rdata", rdata, exp_rdata);
    if (wr) mem[da[7:0]] = wd;
    if (!hold) begin i_req = 1'b0; d_req = 1'b0; end
  endtask

  task automatic idle_cycle();
    tick();
    chk("idle_no_ack", 16'({i_ack, d_ack}), 16'd0);
    chk("idle_strobes", 16'({readM, writeM}), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[8'h10] = 16'hA5A5;
    exp_rdata = 16'h0000;
`ifdef MEM_ARB_RR_EN
    m_last = 1'b0;
`endif
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    input_ready = 1'b0; ack_output = 1'b0;
    tick(); tick();
    chk("rst_readM", 16'(readM), 16'd0);
    chk("rst_writeM", 16'(writeM), 16'd0);
    chk("rst_address", address, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_acks", 16'({i_ack, d_ack}), 16'd0);
    chk("rst_owner", 16'(owner), 16'd0);
    reset_n = 1'b1;
    idle_cycle();

    // Basic fetch and basic write.
    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3, 1'b0, 1'b0);
    chk("fetch_rdata", rdata, 16'hA5A5);
    access(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'h1234, 2, 1'b0, 1'b0);
    idle_cycle();

    // Tie: D first, then I granted right after d_ack.
    access(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0030, 16'h0000, 2, 1'b0, 1'b0);
    access(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    // Back-to-back ties: second tie depends on the arbitration mode.
    access(1'b1, 1'b1, 1'b0, 16'h0051, 16'h0031, 16'h0000, 1, 1'b1, 1'b0);
    access(1'b1, 1'b1, 1'b0, 16'h0051, 16'h0031, 16'h0000, 2, 1'b0, 1'b0);

    // Spurious pulses in IDLE are ignored.
    input_ready = 1'b1; ack_output = 1'b1;
    idle_cycle();
    input_ready = 1'b0; ack_output = 1'b0;
    chk("spur_rdata_kept", rdata, exp_rdata);
    // ack_output during RD_WAIT is ignored; both pulses at completion.
    access(1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 16'h0000, 3, 1'b0, 1'b1);

    // Reset while a read is waiting abandons it.
    i_req = 1'b1; i_addr = 16'h0040;
    tick();
    chk("rst_mid_readM", 16'(readM), 16'd1);
    tick();
    reset_n = 1'b0; input_ready = 1'b1; i_req = 1'b0;
    tick();
    chk("rst_mid_strobe", 16'({readM, writeM}), 16'd0);
    chk("rst_mid_ack", 16'({i_ack, d_ack}), 16'd0);
    chk("rst_mid_rdata", rdata, 16'h0000);
    chk("rst_mid_owner", 16'(owner), 16'd0);
    exp_rdata = 16'h0000;
`ifdef MEM_ARB_RR_EN
    m_last = 1'b0;
`endif
    reset_n = 1'b1; input_ready = 1'b0;
    idle_cycle();

    // Held i_req: three fetches separated by one IDLE cycle each.
    access(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 1'b1, 1'b0);
    access(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1, 1'b1, 1'b0);
    access(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 2, 1'b0, 1'b0);
    idle_cycle();

    // Randomized accesses against the model.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      logic        ir;
      logic        dr;
      kind = $urandom_range(0, 2);
      ir = (kind != 1);
      dr = (kind != 0);
      access(ir, dr, 1'($urandom_range(0, 1)),
             {8'h00, 8'($urandom_range(0, 31))},
             {8'h00, 8'($urandom_range(0, 31))},
             16'($urandom), int'($urandom_range(1, 4)),
             1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
